// File: rtl/ts_capture_pkg.sv
// Shared definitions for the timestamp capture block: widths, word layout,
// continuity FSM states and a saturating counter helper.
package ts_capture_pkg;

  localparam int TS_CW       = 22;
  localparam int TS_DISC_BIT = TS_CW + 1;
  localparam int TS_OVF_BIT  = TS_CW;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    if (en && (v != 8'hFF)) begin
      return v + 8'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word; a stored word
// becomes visible on rd_data/rd_valid one clock after it is written.
module sync_fifo_fwft #(
  parameter int W   = 24,
  parameter int DL2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_data,
  input  logic           rd_en,
  output logic [W-1:0]   rd_data,
  output logic           rd_valid,
  output logic           full,
  output logic           empty,
  output logic [DL2:0]   level
);

  localparam int DEPTH = 1 << DL2;

  logic [W-1:0]   mem_q [DEPTH];
  logic [DL2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DL2:0]   level_q, level_d, remain_s;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;
  logic           rd_s, wr_s;

  assign full     = (level_q == (DL2+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;

  // Next pointers/level; the head register only sees words stored before this edge.
  always_comb begin
    rd_s     = rd_en & valid_q;
    wr_s     = wr_en & (~full | rd_s);
    remain_s = level_q - (DL2+1)'(rd_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      data_d   = '0;
    end else begin
      wr_ptr_d = wr_s ? wr_ptr_q + DL2'(1) : wr_ptr_q;
      rd_ptr_d = rd_s ? rd_ptr_q + DL2'(1) : rd_ptr_q;
      level_d  = remain_s + (DL2+1)'(wr_s);
      valid_d  = (remain_s != '0);
      if (valid_d) begin
        data_d = mem_q[rd_ptr_d];
      end else begin
        data_d = data_q;
      end
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (wr_s && !clr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, level and head-word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/ts_capture.sv
// Timestamp capture: checks counter continuity, captures the counter on trigger
// rising edges into a FWFT FIFO, and keeps drop/discontinuity statistics.
module ts_capture
  import ts_capture_pkg::*;
#(
  parameter int CW         = TS_CW,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [CW-1:0]         counter,
  input  logic                  trig,
  output logic [CW+1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            lost_cnt,
  output logic [7:0]            disc_cnt,
  output logic                  running
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, prev_q, prev_d, cnt_inc_s;
  logic          trig_q, trig_d, trig_prev_q, trig_prev_d;
  logic          primed_q, primed_d;
  logic          pend_disc_q, pend_disc_d, pend_ovf_q, pend_ovf_d;
  logic [7:0]    lost_q, lost_d, disc_q, disc_d;
  logic          running_q, running_d;
  logic          edge_s, disc_ev_s, capture_s, rd_s, drop_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW+1:0] word_s;

  // Continuity FSM, trigger edge, capture decision, flags and statistics.
  always_comb begin
    cnt_d       = counter;
    trig_d      = trig;
    primed_d    = 1'b1;
    cnt_inc_s   = prev_q + CW'(1);
    state_d     = state_q;
    disc_ev_s   = 1'b0;
    // INIT waits one clock after reset so cnt_q holds a real sample.
    case (state_q)
      ST_INIT: begin
        if (!primed_q) begin
          state_d = ST_INIT;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          state_d   = ST_RUN;
          disc_ev_s = (cnt_q != CW'(1));
        end
      end
      ST_RUN: begin
        if (cnt_q == cnt_inc_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          disc_ev_s = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    edge_s    = trig_q & ~trig_prev_q;
    capture_s = edge_s & ((state_q == ST_RUN) | (state_d == ST_RUN));
    rd_s      = out_valid & out_ready & ~fifo_empty_s;
    drop_s    = capture_s & fifo_full_s & ~rd_s;

    word_s              = '0;
    word_s[CW-1:0]      = cnt_q;
    word_s[TS_OVF_BIT]  = pend_ovf_q;
    word_s[TS_DISC_BIT] = pend_disc_q;

    if (capture_s && !drop_s) begin
      pend_disc_d = disc_ev_s;
      pend_ovf_d  = 1'b0;
    end else if (drop_s) begin
      pend_disc_d = pend_disc_q | disc_ev_s;
      pend_ovf_d  = 1'b1;
    end else begin
      pend_disc_d = pend_disc_q | disc_ev_s;
      pend_ovf_d  = pend_ovf_q;
    end

    lost_d      = sat_inc8(lost_q, drop_s);
    disc_d      = sat_inc8(disc_q, disc_ev_s);
    prev_d      = cnt_q;
    trig_prev_d = trig_q;
    running_d   = 1'b0;

    if (clr) begin
      state_d     = ST_INIT;
      prev_d      = '0;
      trig_prev_d = 1'b0;
      pend_disc_d = 1'b0;
      pend_ovf_d  = 1'b0;
      lost_d      = 8'd0;
      disc_d      = 8'd0;
    end else begin
      running_d = (state_d == ST_RUN);
    end
  end

  // State, input sample and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      prev_q      <= '0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      primed_q    <= 1'b0;
      pend_disc_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
      lost_q      <= 8'd0;
      disc_q      <= 8'd0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      trig_q      <= trig_d;
      trig_prev_q <= trig_prev_d;
      primed_q    <= primed_d;
      pend_disc_q <= pend_disc_d;
      pend_ovf_q  <= pend_ovf_d;
      lost_q      <= lost_d;
      disc_q      <= disc_d;
      running_q   <= running_d;
    end
  end

  sync_fifo_fwft #(
    .W   (CW + 2),
    .DL2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (capture_s),
    .wr_data  (word_s),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .level    (fifo_level)
  );

  assign lost_cnt = lost_q;
  assign disc_cnt = disc_q;
  assign running  = running_q;

endmodule

// File: tb/tb_ts_capture.sv
// Bench for ts_capture: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the capture rules.
module tb_ts_capture;

  localparam int M_INIT = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;

  logic        clk = 1'b0;
  logic        rst_n, clr, trig, out_ready;
  logic [21:0] counter;
  logic [23:0] out_data;
  logic        out_valid, running;
  logic [4:0]  fifo_level;
  logic [7:0]  lost_cnt, disc_cnt;

  int checks, failures, pops;

  logic [23:0] q[$];
  int          m_mode, m_lost, m_disc;
  logic [21:0] m_prev, pend_c, cv;
  logic        m_lastt, m_pd, m_po, m_valid, pend_ok, pend_t;
  logic [23:0] last_pop;

  ts_capture dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .counter(counter), .trig(trig),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .lost_cnt(lost_cnt), .disc_cnt(disc_cnt),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = M_INIT; m_prev = 22'd0; m_lastt = 1'b0;
    m_pd = 1'b0; m_po = 1'b0; m_lost = 0; m_disc = 0;
    m_valid = 1'b0; pend_ok = 1'b0; pend_c = 22'd0; pend_t = 1'b0;
  endtask

  // Apply the continuity and capture rules to one registered sample.
  task automatic m_eval(input logic [21:0] c, input logic t);
    logic ev, disc, was_run;
    logic [21:0] nxt;
    ev = t & ~m_lastt;
    m_lastt = t;
    disc = 1'b0;
    was_run = (m_mode == M_RUN);
    nxt = m_prev + 22'd1;
    if (m_mode == M_INIT) begin
      m_mode = (c == 22'd0) ? M_HOLD : M_RUN;
    end else if (m_mode == M_HOLD) begin
      if (c != 22'd0) begin
        disc = (c != 22'd1);
        m_mode = M_RUN;
      end
    end else begin
      if (c == 22'd0 && m_prev != 22'h3FFFFF) m_mode = M_HOLD;
      else if (c != nxt) disc = 1'b1;
    end
    m_prev = c;
    if (ev && (was_run || m_mode == M_RUN)) begin
      if (q.size() < 16) begin
        q.push_back({m_pd, m_po, c});
        m_pd = disc;
        m_po = 1'b0;
      end else begin
        m_pd = m_pd | disc;
        m_po = 1'b1;
        if (m_lost < 255) m_lost++;
      end
    end else begin
      m_pd = m_pd | disc;
    end
    if (disc && m_disc < 255) m_disc++;
  endtask

  task automatic model_step(input logic [21:0] c, input logic t, input logic cl);
    if (cl) begin
      model_reset();
    end else begin
      m_valid = (q.size() != 0);
      if (pend_ok) m_eval(pend_c, pend_t);
    end
    pend_ok = 1'b1; pend_c = c; pend_t = t;
  endtask

  // One clock: drive inputs, compare outputs at negedge, advance model at posedge.
  task automatic tick(input logic [21:0] c, input logic t, input logic rdy, input logic cl);
    counter = c; trig = t; out_ready = rdy; clr = cl;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("fifo_level", fifo_level, q.size());
    chk("lost_cnt", lost_cnt, m_lost);
    chk("disc_cnt", disc_cnt, m_disc);
    chk("running", running, m_mode == M_RUN);
    if (m_valid && q.size() > 0) chk("out_data", out_data, q[0]);
    if (m_valid && rdy && q.size() > 0) begin
      last_pop = q.pop_front();
      pops++;
    end
    @(posedge clk);
    model_step(c, t, cl);
    #1;
  endtask

  task automatic step(input logic t, input logic rdy);
    tick(cv, t, rdy, 1'b0);
    cv = cv + 22'd1;
  endtask

  task automatic stepn(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy);
  endtask

  task automatic pulse(input logic rdy);
    step(1'b1, rdy);
    step(1'b0, rdy);
  endtask

  initial begin
    int p0, r;
    logic tt, rr, cc;
    checks = 0; failures = 0; pops = 0; last_pop = 24'd0;
    rst_n = 1'b0; clr = 1'b0; trig = 1'b0; out_ready = 1'b1; counter = 22'h100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_data", out_data, 24'd0);
    chk("rst_running", running, 1'b0);
    rst_n = 1'b1;
    cv = 22'h100;

    // Basic capture and 3-clock latency.
    while (cv != 22'h201) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("lat_clk1", out_valid, 1'b0);
    step(1'b0, 1'b1);
    chk("lat_clk2", out_valid, 1'b0);
    step(1'b0, 1'b1);
    chk("lat_clk3", out_valid, 1'b1);
    chk("first_word", out_data, {2'b00, 22'h201});
    chk("first_disc", disc_cnt, 8'd0);
    stepn(3, 1'b1);

    // Legal wrap of the counter.
    tick(22'h3FFFF8, 1'b0, 1'b1, 1'b1);
    cv = 22'h3FFFF9;
    while (cv != 22'd0) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    stepn(5, 1'b1);
    chk("wrap_word", last_pop, 24'h000000);
    chk("wrap_disc", disc_cnt, 8'd0);
    chk("wrap_run", running, 1'b1);

    // Discontinuity flagged on next word only.
    while (cv != 22'h11) step(1'b0, 1'b1);
    cv = 22'h50;
    stepn(4, 1'b1);
    pulse(1'b1);
    stepn(4, 1'b1);
    chk("disc_flag1", last_pop[23], 1'b1);
    chk("disc_cnt1", disc_cnt, 8'd1);
    pulse(1'b1);
    stepn(4, 1'b1);
    chk("disc_flag2", last_pop[23], 1'b0);

    // Overflow: 17 edges into a 16-deep FIFO.
    repeat (17) pulse(1'b0);
    stepn(3, 1'b0);
    chk("ovf_level", fifo_level, 5'd16);
    chk("ovf_lost", lost_cnt, 8'd1);
    stepn(20, 1'b1);
    chk("drain_level", fifo_level, 5'd0);
    pulse(1'b1);
    stepn(4, 1'b1);
    chk("ovf_flag", last_pop[23:22], 2'b01);

    // HOLD: edges ignored while the counter is inhibited.
    tick(22'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(22'd0, 1'b1, 1'b1, 1'b0);
      tick(22'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("hold_running", running, 1'b0);
    chk("hold_level", fifo_level, 5'd0);
    chk("hold_lost", lost_cnt, 8'd0);
    cv = 22'd1;
    stepn(3, 1'b1);
    chk("resume_running", running, 1'b1);
    p0 = pops;
    pulse(1'b1);
    stepn(4, 1'b1);
    chk("resume_capture", pops - p0, 1);

    // Full FIFO with a read and a write in the same cycle.
    repeat (16) pulse(1'b0);
    stepn(3, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("fullrw_level", fifo_level, 5'd16);
    chk("fullrw_lost", lost_cnt, 8'd0);

    // Asynchronous reset in the middle of activity.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_level", fifo_level, 5'd0);
    chk("arst_data", out_data, 24'd0);
    chk("arst_running", running, 1'b0);
    chk("arst_lost", lost_cnt, 8'd0);
    chk("arst_disc", disc_cnt, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepn(4, 1'b1);

    // Synchronous clear flushes the FIFO.
    repeat (5) pulse(1'b0);
    stepn(3, 1'b0);
    chk("preclr_level", fifo_level, 5'd5);
    tick(cv, 1'b0, 1'b0, 1'b1);
    cv = cv + 22'd1;
    chk("clr_level", fifo_level, 5'd0);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_data", out_data, 24'd0);

    // Saturation of both statistics counters.
    stepn(4, 1'b0);
    repeat (300) pulse(1'b0);
    chk("lost_sat", lost_cnt, 8'd255);
    for (int i = 0; i < 300; i++) begin
      cv = 22'($urandom);
      step(1'b0, 1'b0);
    end
    chk("disc_sat", disc_cnt, 8'd255);
    stepn(20, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) cv = 22'($urandom);
      else if (r < 4) cv = 22'd0;
      tt = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 499) == 0);
      tick(cv, tt, rr, cc);
      if (!(cv == 22'd0 && $urandom_range(0, 3) != 0)) cv = cv + 22'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
